// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: operation codes and controller states.
package alu_pkg;

  typedef enum logic [2:0] {
    kAND = 3'b000,
    kADD = 3'b001,
    kXOR = 3'b010,
    kSUB = 3'b011,
    kSLL = 3'b100,
    kSRL = 3'b101,
    kMUL = 3'b110,
    kSLT = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  function automatic logic is_shift(alu_op_t op);
    return (op == kSLL) || (op == kSRL);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the core controller (master) and the ALU (slave).
interface seq_alu_if #(parameter int WIDTH = 8);
  import alu_pkg::*;

  logic             InValid;
  logic             InReady;
  alu_op_t          ALUOp;
  logic [WIDTH-1:0] ALUSrcA;
  logic [WIDTH-1:0] ALUSrcB;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Carry;
  logic             Overflow;

  modport master (
    output InValid, ALUOp, ALUSrcA, ALUSrcB, OutReady,
    input  InReady, OutValid, Result, Zero, Carry, Overflow
  );

  modport slave (
    input  InValid, ALUOp, ALUSrcA, ALUSrcB, OutReady,
    output InReady, OutValid, Result, Zero, Carry, Overflow
  );

endinterface

// File: rtl/seq_alu_core.sv
// Combinational core for the single-cycle operations (AND, ADD, XOR, SUB, SLT).
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // Zero-extended subtraction leaves the borrow in the top bit.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      kAND: result = a & b;
      kADD: begin
        result   = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      kXOR: result = a ^ b;
      kSUB: begin
        result   = diff[WIDTH-1:0];
        carry    = diff[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      kSLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: handshake FSM, iterative shifter, shift-add multiplier, output registers.
//   state | meaning
//   IDLE  | ready for a request; InReady high
//   BUSY  | iterating a shift or multiply, one step per cycle
//   DONE  | result valid; held until OutReady
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic      CLK,
  input logic      ResetN,
  seq_alu_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_t       state_q, state_d;
  alu_op_t          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] core_result;
  logic             core_carry;
  logic             core_ovf;
  logic [SHW-1:0]   amt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] it_res;
  logic             it_carry;

  assign amt = bus.ALUSrcB[SHW-1:0];

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op       (bus.ALUOp),
    .a        (bus.ALUSrcA),
    .b        (bus.ALUSrcB),
    .result   (core_result),
    .carry    (core_carry),
    .overflow (core_ovf)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    mul_sum  = '0;
    it_res   = '0;
    it_carry = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.InValid) begin
          op_d = bus.ALUOp;
          a_d  = bus.ALUSrcA;
          b_d  = bus.ALUSrcB;
          hi_d = '0;
          if (is_shift(bus.ALUOp)) begin
            if (amt == '0) begin
              state_d  = DONE;
              result_d = bus.ALUSrcA;
              zero_d   = (bus.ALUSrcA == '0);
              carry_d  = 1'b0;
              ovf_d    = 1'b0;
            end else begin
              state_d = BUSY;
              cnt_d   = amt - 1'b1;
            end
          end else if (bus.ALUOp == kMUL) begin
            state_d = BUSY;
            cnt_d   = SHW'(WIDTH - 1);
          end else begin
            state_d  = DONE;
            result_d = core_result;
            zero_d   = (core_result == '0);
            carry_d  = core_carry;
            ovf_d    = core_ovf;
          end
        end
      end

      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        case (op_q)
          kSLL: begin
            it_res   = a_q << 1;
            it_carry = a_q[WIDTH-1];
            a_d      = it_res;
          end
          kSRL: begin
            it_res   = a_q >> 1;
            it_carry = a_q[0];
            a_d      = it_res;
          end
          kMUL: begin
            // {hi, b} is the running product; the multiplier drains out of b's LSB.
            mul_sum  = {1'b0, hi_q} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
            hi_d     = mul_sum[WIDTH:1];
            b_d      = {mul_sum[0], b_q[WIDTH-1:1]};
            it_res   = b_d;
            it_carry = |hi_d;
          end
          default: ;
        endcase
        if (cnt_q == '0) begin
          state_d  = DONE;
          result_d = it_res;
          zero_d   = (it_res == '0);
          carry_d  = it_carry;
          ovf_d    = 1'b0;
        end
      end

      DONE: begin
        if (bus.OutReady) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state_q  <= IDLE;
      op_q     <= kAND;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.InReady  = (state_q == IDLE);
  assign bus.OutValid = (state_q == DONE);
  assign bus.Result   = result_q;
  assign bus.Zero     = zero_q;
  assign bus.Carry    = carry_q;
  assign bus.Overflow = ovf_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu at WIDTH=8: directed vector table, random ops against a reference model, handshake corners.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .CLK    (clk),
    .ResetN (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op;
    int a;
    int b;
    int res;
    int z;
    int c;
    int v;
    int lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sval(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Reference model written from the operation definitions with plain integer arithmetic.
  function automatic void model(input int op, input int a, input int b,
                                output int r, output int z, output int c,
                                output int v, output int lat);
    int k;
    int t;
    k = b % W;
    c = 0;
    v = 0;
    lat = 1;
    case (op)
      0: r = a & b;
      1: begin
        t = a + b;
        r = t % 256;
        c = (t > 255) ? 1 : 0;
        t = sval(a) + sval(b);
        v = (t > 127 || t < -128) ? 1 : 0;
      end
      2: r = a ^ b;
      3: begin
        r = (a - b + 256) % 256;
        c = (a < b) ? 1 : 0;
        t = sval(a) - sval(b);
        v = (t > 127 || t < -128) ? 1 : 0;
      end
      4: begin
        r = (a * (1 << k)) % 256;
        c = (k == 0) ? 0 : (a / (1 << (W - k))) % 2;
        lat = (k == 0) ? 1 : k + 1;
      end
      5: begin
        r = a / (1 << k);
        c = (k == 0) ? 0 : (a / (1 << (k - 1))) % 2;
        lat = (k == 0) ? 1 : k + 1;
      end
      6: begin
        t = a * b;
        r = t % 256;
        c = (t > 255) ? 1 : 0;
        lat = W + 1;
      end
      default: r = (sval(a) < sval(b)) ? 1 : 0;
    endcase
    z = (r == 0) ? 1 : 0;
  endfunction

  task automatic do_op(input int op, input int a, input int b,
                       output int r, output int z, output int c,
                       output int v, output int lat);
    int w;
    logic [2:0] opb;
    @(negedge clk);
    w = 0;
    while (!bus.InReady && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", (w < 40) ? 1 : 0, 1);
    opb = op[2:0];
    bus.InValid = 1'b1;
    bus.ALUOp   = alu_op_t'(opb);
    bus.ALUSrcA = a[7:0];
    bus.ALUSrcB = b[7:0];
    @(posedge clk);
    #1;
    bus.InValid = 1'b0;
    bus.ALUSrcA = 8'($urandom);
    bus.ALUSrcB = 8'($urandom);
    bus.ALUOp   = alu_op_t'(3'($urandom_range(0, 7)));
    lat = 1;
    while (!bus.OutValid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = int'(bus.Result);
    z = int'(bus.Zero);
    c = int'(bus.Carry);
    v = int'(bus.Overflow);
    @(negedge clk);
    bus.OutReady = 1'b1;
    @(posedge clk);
    #1;
    bus.OutReady = 1'b0;
  endtask

  initial begin
    int r, z, c, v, lat;
    int er, ez, ec, ev, el;
    int a, b, op;
    int seen;

    vecs[0]  = '{1, 'hFF, 'h01, 'h00, 1, 1, 0, 1};
    vecs[1]  = '{3, 'h80, 'h01, 'h7F, 0, 0, 1, 1};
    vecs[2]  = '{7, 'h80, 'h01, 'h01, 0, 0, 0, 1};
    vecs[3]  = '{4, 'h81, 'h01, 'h02, 0, 1, 0, 2};
    vecs[4]  = '{5, 'h81, 'h00, 'h81, 0, 0, 0, 1};
    vecs[5]  = '{5, 'h80, 'h07, 'h01, 0, 0, 0, 8};
    vecs[6]  = '{6, 'h10, 'h11, 'h10, 0, 1, 0, 9};
    vecs[7]  = '{6, 'h0F, 'h0F, 'hE1, 0, 0, 0, 9};
    vecs[8]  = '{0, 'hF0, 'h0F, 'h00, 1, 0, 0, 1};
    vecs[9]  = '{2, 'hA5, 'hFF, 'h5A, 0, 0, 0, 1};
    vecs[10] = '{1, 'h7F, 'h01, 'h80, 0, 0, 1, 1};
    vecs[11] = '{3, 'h00, 'h01, 'hFF, 0, 1, 0, 1};

    bus.InValid  = 1'b0;
    bus.OutReady = 1'b0;
    bus.ALUOp    = kAND;
    bus.ALUSrcA  = '0;
    bus.ALUSrcB  = '0;

    #12;
    chk("rst_outvalid", int'(bus.OutValid), 0);
    chk("rst_inready", int'(bus.InReady), 1);
    chk("rst_result", int'(bus.Result), 0);
    chk("rst_flags", int'({bus.Zero, bus.Carry, bus.Overflow}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, c, v, lat);
      chk($sformatf("vec%0d_result", i), r, vecs[i].res);
      chk($sformatf("vec%0d_zero", i), z, vecs[i].z);
      chk($sformatf("vec%0d_carry", i), c, vecs[i].c);
      chk($sformatf("vec%0d_ovf", i), v, vecs[i].v);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 7);
      a  = $urandom_range(0, 255);
      b  = $urandom_range(0, 255);
      model(op, a, b, er, ez, ec, ev, el);
      do_op(op, a, b, r, z, c, v, lat);
      chk($sformatf("rnd%0d_op%0d_result", i, op), r, er);
      chk($sformatf("rnd%0d_op%0d_zero", i, op), z, ez);
      chk($sformatf("rnd%0d_op%0d_carry", i, op), c, ec);
      chk($sformatf("rnd%0d_op%0d_ovf", i, op), v, ev);
      chk($sformatf("rnd%0d_op%0d_latency", i, op), lat, el);
    end

    // Backpressure: result held, new request ignored while DONE.
    @(negedge clk);
    bus.InValid = 1'b1;
    bus.ALUOp   = kADD;
    bus.ALUSrcA = 8'h11;
    bus.ALUSrcB = 8'h22;
    @(posedge clk);
    #1;
    chk("bp_valid_lat1", int'(bus.OutValid), 1);
    @(negedge clk);
    bus.ALUOp   = kSUB;
    bus.ALUSrcA = 8'h55;
    bus.ALUSrcB = 8'h44;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_result", int'(bus.Result), 'h33);
      chk("bp_flags", int'({bus.Zero, bus.Carry, bus.Overflow}), 0);
      chk("bp_inready", int'(bus.InReady), 0);
      chk("bp_outvalid", int'(bus.OutValid), 1);
    end
    @(negedge clk);
    bus.OutReady = 1'b1;
    bus.InValid  = 1'b0;
    @(posedge clk);
    #1;
    bus.OutReady = 1'b0;
    chk("bp_release_inready", int'(bus.InReady), 1);
    chk("bp_release_outvalid", int'(bus.OutValid), 0);
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.OutValid) seen = 1;
    end
    chk("bp_stale_ignored", seen, 0);
    chk("bp_result_kept", int'(bus.Result), 'h33);

    // Reset during the 4th BUSY cycle of a MUL.
    @(negedge clk);
    bus.InValid = 1'b1;
    bus.ALUOp   = kMUL;
    bus.ALUSrcA = 8'h10;
    bus.ALUSrcB = 8'h11;
    @(posedge clk);
    #1;
    bus.InValid = 1'b0;
    chk("mid_busy_inready", int'(bus.InReady), 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outvalid", int'(bus.OutValid), 0);
    chk("async_rst_inready", int'(bus.InReady), 1);
    chk("async_rst_result", int'(bus.Result), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.OutValid) seen = 1;
    end
    chk("aborted_no_result", seen, 0);
    do_op(1, 3, 4, r, z, c, v, lat);
    chk("post_rst_add_result", r, 7);
    chk("post_rst_add_latency", lat, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the datapath's 2-bit-op combinational ALU.
- Adds WIDTH-generic operands, registered results, a valid/ready handshake on both sides, and Carry/Overflow flags.
- Adds iterative variable shifts, a shift-add multiply and a signed set-less-than.
- Sits between the register-file read stage and writeback. The core controller stalls on InReady/OutValid.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥ 2 and a power of two.
- SHW, $clog2(WIDTH), derived localparam; width of the shift-amount field taken from ALUSrcB.

Ports:
- CLK  in  1  rising-edge clock
- ResetN  in  1  asynchronous, active-low reset
- InValid  in  1  request valid
- InReady  out  1  block can accept a request
- ALUOp  in  3  operation code (alu_op_t)
- ALUSrcA  in  WIDTH  operand A
- ALUSrcB  in  WIDTH  operand B; shifts use ALUSrcB[SHW-1:0] as the amount
- OutValid  out  1  result valid
- OutReady  in  1  consumer accepts the result
- Result  out  WIDTH  registered result
- Zero  out  1  Result == 0
- Carry  out  1  carry/borrow/shift-out/multiply-high flag
- Overflow  out  1  signed overflow (ADD/SUB only)

Behaviour:
- Reset (ResetN low, asynchronous):
  - state = IDLE; OutValid, Result, Zero, Carry, Overflow all 0; internal counters 0.
  - InReady = 1 while held in reset-released IDLE.
  - Asserting reset mid-operation aborts the operation; the result is lost.
- FSM states: IDLE, BUSY, DONE.
  - InReady = (state == IDLE), combinational from state.
  - IDLE: when InValid, capture ALUOp/ALUSrcA/ALUSrcB. Single-cycle ops go to DONE. SLL/SRL with amount k > 0, and MUL, go to BUSY. SLL/SRL with k = 0 go to DONE.
  - BUSY: one iteration per cycle. When the iteration counter expires, go to DONE.
  - DONE: OutValid = 1. On OutReady, go to IDLE. Result and flags are held stable until OutReady.
- Latency from accept edge to OutValid high:
  - Single-cycle ops, and shifts with k = 0: 1 cycle.
  - Shifts with k > 0: k+1 cycles.
  - MUL: WIDTH+1 cycles.
- Throughput: at most one request in flight. No request is accepted in BUSY or DONE. Inputs are ignored outside IDLE. Captured operands are immune to later input changes.
- Op codes (all WIDTH-bit, modulo 2^WIDTH):
  - 000 AND: Carry = 0, Overflow = 0.
  - 001 ADD: Carry = unsigned carry-out; Overflow = signed overflow.
  - 010 XOR: Carry = 0, Overflow = 0.
  - 011 SUB (A−B): Carry = borrow (A < B unsigned); Overflow = signed overflow.
  - 100 SLL by k, one bit per cycle: Carry = last bit shifted out (0 if k = 0).
  - 101 SRL by k, logical, one bit per cycle: Carry = last bit shifted out (0 if k = 0).
  - 110 MUL, unsigned shift-add over WIDTH cycles: Result = low WIDTH bits of the product; Carry = high half of the 2·WIDTH product is nonzero.
  - 111 SLT, signed: Result = 1 if $signed(A) < $signed(B), else 0; Carry = 0.
- Overflow = 0 for every op except ADD and SUB.
- Zero is computed on the final Result.
- Flags update only on the transition into DONE.

Decomposition:
- Package alu_pkg:
  - typedef enum logic [2:0] alu_op_t: kAND, kADD, kXOR, kSUB, kSLL, kSRL, kMUL, kSLT.
  - typedef enum logic [1:0] alu_state_t: IDLE, BUSY, DONE.
- Sub-module alu_core: parametrised combinational core for the four single-cycle ops plus SLT. It returns Result, Carry and Overflow.
- The top level owns the FSM, the handshake, the shift and multiply iterators, and the output registers.

Test Plan (WIDTH = 8):
- ADD FF+01: Result 00, Zero 1, Carry 1, Overflow 0; OutValid exactly 1 cycle after the accept edge.
- SUB 80−01: Result 7F, Carry 0, Overflow 1. Then SLT 80,01: Result 01.
- SLL 81 by 1: Result 02, Carry 1, latency 2. SRL 81 by 0: Result 81, Carry 0, latency 1. SRL 80 by 7: Result 01, latency 8.
- MUL 10×11: Result 10, Carry 1, Zero 0, latency 9. MUL 0F×0F: Result E1, Carry 0.
- Backpressure: OutReady low for 5 cycles after DONE.
  - Result and flags are held and InReady stays 0.
  - A concurrent InValid with new operands is ignored.
  - On OutReady, InReady rises the next cycle.
- Drop ResetN on the 4th BUSY cycle of a MUL: OutValid goes 0 asynchronously. After release, InReady = 1, and ADD 03+04 returns 07 with latency 1.
